otter_io_timer: RTL and testbench

//  Memory-mapped IOBUS responder for the OTTER MCU: the device end of the

---
 rtl/otter_io_pkg.sv | 19 +
 rtl/otter_io_prescaler.sv | 26 ++
 rtl/otter_io_timer.sv | 95 +++++++++
 tb/tb_otter_io_timer.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/otter_io_pkg.sv
// Shared register map and CTRL field layout for the OTTER IOBUS timer.
package otter_io_pkg;

  localparam logic [3:0] CTRL_OFS  = 4'h0;
  localparam logic [3:0] LOAD_OFS  = 4'h4;
  localparam logic [3:0] COUNT_OFS = 4'h8;
  localparam logic [3:0] STAT_OFS  = 4'hC;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_AR_BIT  = 1;
  localparam int CTRL_IRQ_BIT = 2;

  typedef struct packed {
    logic irq_en;
    logic auto_reload;
    logic en;
  } ctrl_t;

endpackage

// File: rtl/otter_io_prescaler.sv
// Divides CLK down to a one-cycle tick every PRESCALE cycles while enabled.
module otter_io_prescaler #(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] cnt;

  assign tick = en & (cnt == LAST);

  // Held at zero when disabled so a fresh enable always starts a full period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 cnt <= '0;
    else if (clr | ~en | tick)  cnt <= '0;
    else                        cnt <= cnt + PW'(1);
  end

endmodule

// File: rtl/otter_io_timer.sv
// IOBUS-mapped down-counting timer with CTRL/LOAD/COUNT/STAT registers and level INTR.
module otter_io_timer
  import otter_io_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
  parameter int          PRESCALE  = 4,
  parameter int          CNT_W     = 32
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] IOBUS_RD,
  output logic        IOBUS_HIT,
  output logic        INTR
);

  ctrl_t            ctrl;
  logic [CNT_W-1:0] load;
  logic [CNT_W-1:0] count;
  logic             pend;

  logic [3:0]       ofs;
  logic             ctrl_wr, load_wr, stat_wr;
  logic             tick, tick_eff, expire, pre_clr;
  logic [CNT_W-1:0] wdata;
  logic             unused_bits;

  assign IOBUS_HIT = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
  assign ofs       = {IOBUS_ADDR[3:2], 2'b00};
  assign wdata     = IOBUS_OUT[CNT_W-1:0];
  assign unused_bits = ^{IOBUS_ADDR[1:0], IOBUS_OUT};

  assign ctrl_wr = IOBUS_WR & IOBUS_HIT & (ofs == CTRL_OFS);
  assign load_wr = IOBUS_WR & IOBUS_HIT & (ofs == LOAD_OFS);
  assign stat_wr = IOBUS_WR & IOBUS_HIT & (ofs == STAT_OFS);

  // A LOAD write, or a CTRL write that switches EN on, restarts the prescale period.
  assign pre_clr = load_wr | (ctrl_wr & IOBUS_OUT[CTRL_EN_BIT] & ~ctrl.en);

  otter_io_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk   (CLK),
    .rst_n (RESET_N),
    .en    (ctrl.en),
    .clr   (pre_clr),
    .tick  (tick)
  );

  // Same-edge bus writes of LOAD, or of CTRL clearing EN, override the tick.
  assign tick_eff = tick & ~load_wr & ~(ctrl_wr & ~IOBUS_OUT[CTRL_EN_BIT]);
  assign expire   = tick_eff & (count == '0);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      ctrl  <= '0;
      load  <= '0;
      count <= '0;
      pend  <= 1'b0;
    end else begin
      if (ctrl_wr)
        ctrl <= ctrl_t'(IOBUS_OUT[CTRL_IRQ_BIT:CTRL_EN_BIT]);
      else if (expire && !ctrl.auto_reload)
        ctrl.en <= 1'b0;

      if (load_wr) begin
        load  <= wdata;
        count <= wdata;
      end else if (tick_eff) begin
        if (count != '0)           count <= count - CNT_W'(1);
        else if (ctrl.auto_reload) count <= load;
      end

      // Expiry wins over a same-edge write-1-to-clear.
      if (expire)                       pend <= 1'b1;
      else if (stat_wr && IOBUS_OUT[0]) pend <= 1'b0;
    end
  end

  assign INTR = pend & ctrl.irq_en;

  always_comb begin
    IOBUS_RD = '0;
    if (IOBUS_HIT) begin
      case (ofs)
        CTRL_OFS:  IOBUS_RD = {29'b0, ctrl};
        LOAD_OFS:  IOBUS_RD = 32'(load);
        COUNT_OFS: IOBUS_RD = 32'(count);
        STAT_OFS:  IOBUS_RD = {31'b0, pend};
        default:   IOBUS_RD = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_otter_io_timer.sv
// Scoreboard bench for otter_io_timer: directed scenarios plus random bus traffic against a reference model.
module tb_otter_io_timer;

  localparam logic [31:0] BASE = 32'h1100_0100;
  localparam int P = 4;

  logic        CLK = 1'b0;
  logic        RESET_N;
  logic [31:0] IOBUS_ADDR, IOBUS_OUT, IOBUS_RD;
  logic        IOBUS_WR, IOBUS_HIT, INTR;

  always #5 CLK = ~CLK;

  otter_io_timer #(.BASE_ADDR(BASE), .PRESCALE(P), .CNT_W(32)) dut (
    .CLK        (CLK),
    .RESET_N    (RESET_N),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .IOBUS_RD   (IOBUS_RD),
    .IOBUS_HIT  (IOBUS_HIT),
    .INTR       (INTR)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference model: registers as plain variables, prescale phase as an integer.
  logic        m_en, m_auto, m_irq, m_pend;
  logic [31:0] m_load, m_count;
  int          m_phase;

  task automatic model_reset();
    m_en = 0; m_auto = 0; m_irq = 0; m_pend = 0;
    m_load = 0; m_count = 0; m_phase = 0;
  endtask

  function automatic logic m_hit(input logic [31:0] a);
    return a[31:4] == BASE[31:4];
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (!m_hit(a)) return 32'h0;
    case (a[3:2])
      2'd0:    return {29'b0, m_irq, m_auto, m_en};
      2'd1:    return m_load;
      2'd2:    return m_count;
      default: return {31'b0, m_pend};
    endcase
  endfunction

  task automatic model_step(input logic [31:0] a, input logic w, input logic [31:0] d);
    logic        lw, cw, sw, tk, ex;
    logic [31:0] nc;
    lw = w && m_hit(a) && a[3:2] == 2'd1;
    cw = w && m_hit(a) && a[3:2] == 2'd0;
    sw = w && m_hit(a) && a[3:2] == 2'd3;
    tk = m_en && (m_phase == P - 1) && !lw && !(cw && !d[0]);
    ex = tk && (m_count == 0);
    nc = m_count;
    if (lw) nc = d;
    else if (tk) nc = (m_count != 0) ? m_count - 1 : (m_auto ? m_load : 32'h0);
    if (lw) m_phase = 0;
    else    m_phase = m_en ? (m_phase + 1) % P : 0;
    m_count = nc;
    if (lw) m_load = d;
    if (ex) m_pend = 1;
    else if (sw && d[0]) m_pend = 0;
    if (cw) begin
      m_en = d[0]; m_auto = d[1]; m_irq = d[2];
    end else if (ex && !m_auto) begin
      m_en = 0;
    end
  endtask

  typedef struct {
    logic [31:0] rd;
    logic        hit;
    logic        intr;
    int          id;
  } exp_t;

  exp_t        q[$];
  int          ncyc = 0;
  logic [31:0] cur_a, cur_d;
  logic        cur_w;

  function automatic exp_t expect_now();
    exp_t e;
    e.rd = m_read(cur_a); e.hit = m_hit(cur_a); e.intr = m_pend & m_irq; e.id = ncyc;
    return e;
  endfunction

  // One bus cycle: commit the previous inputs into the model at the edge, then apply new ones.
  task automatic drive(input logic [31:0] a, input logic w, input logic [31:0] d);
    @(posedge CLK);
    if (RESET_N) model_step(cur_a, cur_w, cur_d);
    #1;
    cur_a = a; cur_w = w; cur_d = d;
    IOBUS_ADDR = a; IOBUS_WR = w; IOBUS_OUT = d;
    q.push_back(expect_now());
    ncyc++;
    #1;
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check($sformatf("rd@%0d", e.id), IOBUS_RD, e.rd);
      check($sformatf("hit@%0d", e.id), 32'(IOBUS_HIT), 32'(e.hit));
      check($sformatf("intr@%0d", e.id), 32'(INTR), 32'(e.intr));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int rise;
    int rises[4];
    int nr;
    logic prev, clr;
    logic [31:0] a, d;

    RESET_N = 0;
    cur_a = BASE + 32'h8; cur_w = 0; cur_d = 0;
    IOBUS_ADDR = cur_a; IOBUS_WR = 0; IOBUS_OUT = 0;
    model_reset();
    #1;
    check("reset_rd", IOBUS_RD, 32'h0);
    check("reset_intr", 32'(INTR), 32'h0);
    check("reset_hit", 32'(IOBUS_HIT), 32'h1);
    drive(BASE + 32'h8, 0, 0);
    drive(BASE + 32'h8, 0, 0);
    RESET_N = 1;

    // One-shot expiry timing
    drive(BASE + 32'h4, 1, 3);
    drive(BASE + 32'h0, 1, 5);
    rise = -1;
    for (int i = 0; i < 40; i++) begin
      drive(BASE + 32'h0, 0, 0);
      if (INTR === 1'b1) begin rise = i; break; end
    end
    check("oneshot_rise", 32'(rise), 32'd16);
    check("oneshot_ctrl", IOBUS_RD, 32'h4);
    drive(BASE + 32'h8, 0, 0);
    check("oneshot_count", IOBUS_RD, 32'h0);
    drive(BASE + 32'hC, 1, 1);
    drive(BASE + 32'hC, 0, 0);
    check("oneshot_cleared", 32'(INTR), 32'h0);

    // Auto-reload period with software clearing
    drive(BASE + 32'h4, 1, 1);
    drive(BASE + 32'h0, 1, 7);
    nr = 0; prev = 0; clr = 0;
    for (int i = 0; i < 41; i++) begin
      drive(BASE + 32'hC, clr, 1);
      clr = 0;
      if (IOBUS_RD[0] && !prev && nr < 4) begin rises[nr] = i; nr++; clr = 1; end
      prev = IOBUS_RD[0];
    end
    check("ar_nrises", 32'(nr >= 3), 32'h1);
    check("ar_first", 32'(rises[0]), 32'd8);
    check("ar_period1", 32'(rises[1] - rises[0]), 32'd8);
    check("ar_period2", 32'(rises[2] - rises[1]), 32'd8);
    for (int i = 0; i < 16; i++) drive(BASE + 32'h8, 0, 0);
    drive(BASE + 32'h0, 1, 0);
    drive(BASE + 32'hC, 1, 1);

    // W1C on the expiry edge: set wins
    drive(BASE + 32'h4, 1, 1);
    drive(BASE + 32'h0, 1, 7);
    for (int i = 0; i <= 16; i++) begin
      if (i == 15) drive(BASE + 32'hC, 1, 1);
      else         drive(BASE + 32'hC, 0, 0);
    end
    check("w1c_expire_pend", IOBUS_RD, 32'h1);
    check("w1c_expire_intr", 32'(INTR), 32'h1);
    drive(BASE + 32'h0, 1, 0);
    drive(BASE + 32'hC, 1, 1);

    // LOAD write on a tick edge, COUNT is read-only
    drive(BASE + 32'h4, 1, 20);
    drive(BASE + 32'h0, 1, 1);
    for (int i = 0; i <= 10; i++) begin
      if (i == 7)      drive(BASE + 32'h4, 1, 10);
      else if (i == 9) drive(BASE + 32'h8, 1, 5);
      else             drive(BASE + 32'h8, 0, 0);
      if (i == 8)  check("load_on_tick", IOBUS_RD, 32'd10);
      if (i == 10) check("count_ro", IOBUS_RD, 32'd10);
    end
    drive(BASE + 32'h0, 1, 0);

    // Writes outside the window
    drive(BASE + 32'h10, 1, 32'hFFFF_FFFF);
    check("oow_hi_hit", 32'(IOBUS_HIT), 32'h0);
    check("oow_hi_rd", IOBUS_RD, 32'h0);
    drive(32'h1100_0000, 1, 7);
    check("oow_lo_hit", 32'(IOBUS_HIT), 32'h0);
    drive(BASE + 32'h0, 0, 0);
    check("oow_ctrl_unchanged", IOBUS_RD, 32'h0);

    // Asynchronous reset mid-count with INTR active
    drive(BASE + 32'h4, 1, 5);
    drive(BASE + 32'h0, 1, 7);
    for (int i = 0; i < 30; i++) drive(BASE + 32'h8, 0, 0);
    check("pre_reset_intr", 32'(INTR), 32'h1);
    RESET_N = 0;
    model_reset();
    q.delete();
    q.push_back(expect_now());
    #1;
    check("midrst_rd", IOBUS_RD, 32'h0);
    check("midrst_intr", 32'(INTR), 32'h0);
    drive(BASE + 32'h8, 0, 0);
    drive(BASE + 32'h8, 0, 0);
    RESET_N = 1;

    // Random bus traffic
    for (int i = 0; i < 500; i++) begin
      logic w;
      a = BASE + 32'($urandom_range(0, 15));
      if ($urandom_range(0, 19) == 0) a = $urandom;
      w = ($urandom_range(0, 3) == 0);
      d = $urandom;
      if (a[3:2] == 2'd1) d = 32'($urandom_range(0, 6));
      if (a[3:2] == 2'd0 && $urandom_range(0, 3) != 0) d[0] = 1'b1;
      drive(a, w, d);
    end

    drive(BASE + 32'h8, 0, 0);
    @(negedge CLK);
    #1;
    check("queue_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
